// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - sizing helpers and parameter legality checks for pipelined_sync_fifo
package fifo_pkg;

  localparam int FIFO_MAX_OUT_STAGES = 2;

  function automatic int fifo_cnt_width(input int depth, input int stages);
    return $clog2(depth + stages + 1);
  endfunction

  function automatic bit fifo_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int stages, input int afull);
    return fifo_is_pow2(depth) && (stages >= 0) && (stages <= FIFO_MAX_OUT_STAGES) &&
           (afull <= depth + stages);
  endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - one valid/data prefetch register on the FIFO read side
module fifo_out_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  // load means this slot is free or its word is leaving this cycle
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipelined_sync_fifo.sv
// rtl/pipelined_sync_fifo.sv - single-clock show-ahead FIFO with 0..2 registered prefetch stages
module pipelined_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int OUT_STAGES    = 2,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1,
  localparam int CNT_WIDTH    = fifo_cnt_width(FIFO_DEPTH, OUT_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

  if (!fifo_params_ok(FIFO_DEPTH, OUT_STAGES, AFULL_THRESH)) begin : g_bad_params
    $fatal(1, "pipelined_sync_fifo: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  fill_d, fill_q;
  logic                  overflow_d, overflow_q, underflow_d, underflow_q;
  logic                  storage_empty, storage_full, push_acc, pop_acc, rd_fire;

  // index 0 is the storage head; index OUT_STAGES is the visible head word
  logic                  chain_valid [OUT_STAGES+1];
  logic [DATA_WIDTH-1:0] chain_data  [OUT_STAGES+1];
  logic                  chain_ready [OUT_STAGES+1];

  assign storage_empty = (wr_ptr_q == rd_ptr_q);
  assign storage_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                         (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign chain_valid[0] = !storage_empty;
  assign chain_data[0]  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  // source i may hand its word on when any downstream slot is empty or the head is popped
  always_comb begin
    for (int i = 0; i <= OUT_STAGES; i++) begin
      chain_ready[i] = pop;
      for (int j = i + 1; j <= OUT_STAGES; j++) begin
        if (!chain_valid[j]) chain_ready[i] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < OUT_STAGES; k++) begin : g_stage
    fifo_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load      (chain_ready[k]),
      .in_valid  (chain_valid[k]),
      .in_data   (chain_data[k]),
      .out_valid (chain_valid[k+1]),
      .out_data  (chain_data[k+1])
    );
  end

  assign out_valid = chain_valid[OUT_STAGES];
  assign out_data  = chain_data[OUT_STAGES];
  assign in_ready  = !storage_full;
  assign push_acc  = push && !storage_full && !flush;
  assign pop_acc   = pop && out_valid && !flush;
  assign rd_fire   = chain_ready[0] && chain_valid[0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    overflow_d  = push && storage_full && !flush;
    underflow_d = pop && !out_valid && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
      if (rd_fire)  rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
      fill_d = fill_q + CNT_WIDTH'(push_acc) - CNT_WIDTH'(pop_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fill_level   = fill_q;
  assign almost_full  = (fill_q >= CNT_WIDTH'(AFULL_THRESH));
  assign almost_empty = (fill_q <= CNT_WIDTH'(AEMPTY_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
